// File: rtl/pc_pipe.sv
// pc_pipe: program-counter unit for the ARMv4 front end.
// Produces the fetch address and carries PC, instruction-set state and a
// valid bit through decode and execute. Exception, branch and sequential
// redirects are arbitrated here; wrong-path stages are flushed on redirect.
module pc_pipe #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]    VEC_BASE  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              i_exc_valid,
  input  logic [2:0]        i_exc_idx,
  input  logic              i_pc_en,
  input  logic [ADDR_W-1:0] i_pc_reg,
  input  logic              i_pc_thumb,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_thumb,
  output logic [ADDR_W-1:0] o_dec_pc,
  output logic [ADDR_W-1:0] o_ex_pc,
  output logic              o_dec_valid,
  output logic              o_ex_valid,
  output logic              o_dec_thumb,
  output logic              o_ex_thumb,
  output logic [ADDR_W-1:0] o_ex_pc_read,
  output logic              o_flush
);

  // Low two bits of the reset vector are never honoured.
  localparam logic [ADDR_W-1:0] RST_PC = RESET_VEC & ~ADDR_W'(3);

  // Clear the bits that cannot be set for the given instruction set.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr,
                                                 input logic              thumb);
    align_pc = thumb ? (addr & ~ADDR_W'(1)) : (addr & ~ADDR_W'(3));
  endfunction

  // Sequential fetch step: one halfword in Thumb, one word in ARM.
  function automatic logic [ADDR_W-1:0] seq_step(input logic thumb);
    seq_step = thumb ? ADDR_W'(2) : ADDR_W'(4);
  endfunction

  // Architectural PC read offset: two instructions ahead of execute.
  function automatic logic [ADDR_W-1:0] read_off(input logic thumb);
    read_off = thumb ? ADDR_W'(4) : ADDR_W'(8);
  endfunction

  logic [ADDR_W-1:0] pc_p0, pc_p1, pc_p2;
  logic              thumb_p0, thumb_p1, thumb_p2;
  logic              vld_p1, vld_p2;
  logic [ADDR_W-1:0] pc_nxt;
  logic              thumb_nxt;
  logic [ADDR_W-1:0] exc_vec;

  assign exc_vec = (VEC_BASE + (ADDR_W'(i_exc_idx) << 2)) & ~ADDR_W'(3);

  // Next fetch address select: exception, then branch, then sequential.
  always_comb begin
    pc_nxt    = pc_p0 + seq_step(thumb_p0);
    thumb_nxt = thumb_p0;
    if (i_exc_valid) begin
      pc_nxt    = exc_vec;
      thumb_nxt = 1'b0;
    end else if (i_pc_en) begin
      pc_nxt    = align_pc(i_pc_reg, i_pc_thumb);
      thumb_nxt = i_pc_thumb;
    end
  end

  assign o_flush = en & (i_exc_valid | i_pc_en);

  // ---- fetch stage (p0) ----
  // Fetch PC and mode register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0    <= RST_PC;
      thumb_p0 <= 1'b0;
    end else if (en) begin
      pc_p0    <= pc_nxt;
      thumb_p0 <= thumb_nxt;
    end
  end

  // ---- decode stage (p1) ----
  // Fetched instruction enters decode; a redirect marks it wrong-path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p1    <= '0;
      thumb_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (en) begin
      pc_p1    <= pc_p0;
      thumb_p1 <= thumb_p0;
      vld_p1   <= ~o_flush;
    end
  end

  // ---- execute stage (p2) ----
  // Decode moves to execute; the redirecting instruction itself is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p2    <= '0;
      thumb_p2 <= 1'b0;
      vld_p2   <= 1'b0;
    end else if (en) begin
      pc_p2    <= pc_p1;
      thumb_p2 <= thumb_p1;
      vld_p2   <= vld_p1 & ~o_flush;
    end
  end

  assign o_pc         = pc_p0;
  assign o_pc_next    = pc_nxt;
  assign o_thumb      = thumb_p0;
  assign o_dec_pc     = pc_p1;
  assign o_dec_valid  = vld_p1;
  assign o_dec_thumb  = thumb_p1;
  assign o_ex_pc      = pc_p2;
  assign o_ex_valid   = vld_p2;
  assign o_ex_thumb   = thumb_p2;
  assign o_ex_pc_read = pc_p2 + read_off(thumb_p2);

endmodule
